// File: rtl/bus_slave_pkg.sv
// Shared types for the bit-serial bus slave: FSM state encoding and transaction mode values.
package bus_slave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRITE = 3'd3,
        RLOAD = 3'd4,
        RSEND = 3'd5
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_slave_if.sv
// Serial bus between a master and the memory slave; clock and reset are carried separately.
interface bus_slave_if;
    logic swdata;
    logic smode;
    logic mvalid;
    logic srdata;
    logic svalid;
    logic sready;

    modport master (output swdata, output smode, output mvalid,
                    input  srdata, input  svalid, input  sready);
    modport slave  (input  swdata, input  smode, input  mvalid,
                    output srdata, output svalid, output sready);
endinterface

// File: rtl/bus_slave_mem.sv
// Single-port synchronous RAM with a registered read port; contents are not reset.
module bus_slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_slave.sv
// Bit-serial memory slave: shifts in address and write data LSB first, serialises read data back out.
module bus_slave
    import bus_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    bus_slave_if.slave  bus
);
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  mode_q, mode_d;
    logic                  srdata_q, srdata_d;
    logic                  svalid_q, svalid_d;
    logic                  sready_q, sready_d;
    logic                  mem_we_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // The RAM is addressed with the next address so a read issued on the last
    // address bit has its word ready during RLOAD.
    bus_slave_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (addr_d),
        .wdata_i (data_q),
        .rdata_o (rdata_s)
    );

    // Next-state, field shifting and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mode_d   = mode_q;
        shift_d  = shift_q;
        srdata_d = 1'b0;
        svalid_d = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mvalid) begin
                    addr_d  = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
                    mode_d  = bus.smode;
                    cnt_d   = CNT_ONE;
                    state_d = ADDR;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ADDR: begin
                if (bus.mvalid) begin
                    addr_d = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == LAST_A) begin
                        cnt_d   = CNT_ZERO;
                        state_d = (mode_q == MODE_READ) ? RLOAD : WDATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d   = CNT_ZERO;
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    data_d  = {DATA_WIDTH{1'b0}};
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (bus.mvalid) begin
                    data_d = {bus.swdata, data_q[DATA_WIDTH-1:1]};
                    if (cnt_q == LAST_D) begin
                        cnt_d   = CNT_ZERO;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d   = CNT_ZERO;
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    data_d  = {DATA_WIDTH{1'b0}};
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_we_s = 1'b1;
                state_d  = IDLE;
            end
            RLOAD: begin
                shift_d  = {1'b0, rdata_s[DATA_WIDTH-1:1]};
                srdata_d = rdata_s[0];
                svalid_d = 1'b1;
                cnt_d    = CNT_ZERO;
                state_d  = RSEND;
            end
            RSEND: begin
                if (cnt_q == LAST_D) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                    srdata_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    svalid_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
        sready_d = (state_d == IDLE);
    end

    // State, field and registered-output update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            data_q   <= {DATA_WIDTH{1'b0}};
            shift_q  <= {DATA_WIDTH{1'b0}};
            mode_q   <= MODE_READ;
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
            sready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            mode_q   <= mode_d;
            srdata_q <= srdata_d;
            svalid_q <= svalid_d;
            sready_q <= sready_d;
        end
    end

    assign bus.srdata = srdata_q;
    assign bus.svalid = svalid_q;
    assign bus.sready = sready_q;
endmodule

// File: tb/tb_bus_slave.sv
// Directed bench for bus_slave: a table of write/read transactions plus hand-built abort and reset sequences.
module tb_bus_slave;
    import bus_slave_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    bus_slave_if bus_if ();

    bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic mode, input logic [AW-1:0] a, input int nbits);
        bus_if.smode = mode;
        for (int i = 0; i < nbits; i++) begin
            bus_if.mvalid = 1'b1;
            bus_if.swdata = a[i];
            tick();
            bus_if.smode = ~mode;
            if (i == 0) chk("sready_busy", 32'(bus_if.sready), 32'd0);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_addr(MODE_WRITE, a, AW);
        for (int i = 0; i < DW; i++) begin
            bus_if.swdata = d[i];
            tick();
        end
        chk("sready_write", 32'(bus_if.sready), 32'd0);
        bus_if.mvalid = 1'b0;
        bus_if.swdata = 1'b0;
        tick();
        chk("sready_after_write", 32'(bus_if.sready), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic toggle, output logic [DW-1:0] q);
        q = '0;
        send_addr(MODE_READ, a, AW);
        chk("svalid_rload", 32'(bus_if.svalid), 32'd0);
        bus_if.mvalid = 1'b0;
        tick();
        for (int i = 0; i < DW; i++) begin
            chk("svalid_on", 32'(bus_if.svalid), 32'd1);
            chk("sready_rsend", 32'(bus_if.sready), 32'd0);
            q[i] = bus_if.srdata;
            if (toggle) begin
                bus_if.mvalid = 1'($urandom);
                bus_if.swdata = 1'($urandom);
            end
            tick();
        end
        bus_if.mvalid = 1'b0;
        bus_if.swdata = 1'b0;
        chk("svalid_off", 32'(bus_if.svalid), 32'd0);
        chk("srdata_off", 32'(bus_if.srdata), 32'd0);
        chk("sready_after_read", 32'(bus_if.sready), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] q;

        vecs[0] = '{1'b1, 12'h4D5, 8'hD5};
        vecs[1] = '{1'b0, 12'h4D5, 8'hD5};
        vecs[2] = '{1'b1, 12'h001, 8'h3C};
        vecs[3] = '{1'b1, 12'h000, 8'hFF};
        vecs[4] = '{1'b1, 12'hFFF, 8'h00};
        vecs[5] = '{1'b0, 12'h000, 8'hFF};
        vecs[6] = '{1'b0, 12'hFFF, 8'h00};
        vecs[7] = '{1'b0, 12'h001, 8'h3C};

        rstn          = 1'b0;
        bus_if.mvalid = 1'b0;
        bus_if.swdata = 1'b0;
        bus_if.smode  = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus_if.mvalid = 1'($urandom);
            bus_if.swdata = 1'($urandom);
            bus_if.smode  = 1'($urandom);
            tick();
            chk("rst_srdata", 32'(bus_if.srdata), 32'd0);
            chk("rst_svalid", 32'(bus_if.svalid), 32'd0);
            chk("rst_sready", 32'(bus_if.sready), 32'd1);
        end
        bus_if.mvalid = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_sready", 32'(bus_if.sready), 32'd1);
            chk("idle_svalid", 32'(bus_if.svalid), 32'd0);
        end

        // Table of transactions
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data);
            end else begin
                do_read(vecs[v].addr, 1'b0, q);
                chk("table_read", 32'(q), 32'(vecs[v].data));
            end
        end

        // Abort during address phase
        send_addr(MODE_WRITE, 12'h4D5, 5);
        bus_if.mvalid = 1'b0;
        tick();
        chk("abort_addr_sready", 32'(bus_if.sready), 32'd1);
        tick();
        do_read(12'h4D5, 1'b0, q);
        chk("abort_addr_read", 32'(q), 32'hD5);

        // Abort during data phase
        send_addr(MODE_WRITE, 12'h4D5, AW);
        for (int i = 0; i < 4; i++) begin
            bus_if.swdata = i[0] ? 1'b0 : 1'b1;
            tick();
        end
        bus_if.mvalid = 1'b0;
        tick();
        chk("abort_data_sready", 32'(bus_if.sready), 32'd1);
        tick();
        do_read(12'h4D5, 1'b0, q);
        chk("abort_data_read", 32'(q), 32'hD5);

        // Overwrite, read back while master toggles inputs
        do_write(12'h123, 8'hA5);
        do_write(12'h123, 8'h5A);
        do_read(12'h123, 1'b1, q);
        chk("overwrite_read", 32'(q), 32'h5A);
        tick();

        // Reset during the 4th svalid cycle (bit3 of 0x5A is 1)
        send_addr(MODE_READ, 12'h123, AW);
        bus_if.mvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_svalid", 32'(bus_if.svalid), 32'd1);
        chk("pre_rst_srdata", 32'(bus_if.srdata), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_svalid", 32'(bus_if.svalid), 32'd0);
        chk("midrst_srdata", 32'(bus_if.srdata), 32'd0);
        chk("midrst_sready", 32'(bus_if.sready), 32'd1);
        #2;
        rstn = 1'b1;
        tick();
        do_read(12'h123, 1'b0, q);
        chk("post_rst_read", 32'(q), 32'h5A);
        do_read(12'h4D5, 1'b0, q);
        chk("post_rst_read2", 32'(q), 32'hD5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
